// File: rtl/imem_loader.sv
// Instruction RAM with a byte-stream loader: packs a length-prefixed byte frame into
// words, writes them from address 0 upward, and holds the CPU in reset until a load completes.
module imem_loader #(
    parameter int MEMORY_WORD_SIZE = 32,
    parameter int RAM_SIZE         = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [7:0]                  s_data,
    output logic                        s_ready,
    input  logic                        reload,
    input  logic [RAM_SIZE-1:0]         addrI,
    output logic [MEMORY_WORD_SIZE-1:0] doutI,
    output logic                        cpu_rst,
    output logic                        load_done,
    output logic                        load_err,
    output logic [RAM_SIZE:0]           word_count
);

    localparam int W     = MEMORY_WORD_SIZE;
    localparam int BYTES = W / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DEPTH = 2 ** RAM_SIZE;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        DONE,
        ERROR
    } state_t;

    state_t              r_state;
    logic [15:0]         r_n;
    logic [IDXW-1:0]     r_byte_idx;
    logic [W-1:0]        r_shreg;
    logic [W-1:0]        r_mem [DEPTH];

    logic                w_accept;
    logic                w_last_byte;
    logic                w_wr_en;
    logic [15:0]         w_n_full;
    logic [W+7:0]        w_ext;
    logic [W-1:0]        w_word;
    logic [16:0]         w_wc_next;

    assign s_ready     = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
    assign w_accept    = s_valid && s_ready;
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_wr_en     = !rst && w_accept && (r_state == DATA) && w_last_byte;
    assign w_n_full    = {r_n[15:8], s_data};
    // Truncating the concatenation keeps the shift well-formed even for 8-bit words.
    assign w_ext       = {r_shreg, s_data};
    assign w_word      = w_ext[W-1:0];
    assign w_wc_next   = 17'(word_count) + 17'd1;

    // Write port has no reset so a mid-load rst leaves earlier words intact; reads return old data on collision.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[word_count[RAM_SIZE-1:0]] <= w_word;
        end
        if (rst) begin
            doutI <= '0;
        end else begin
            doutI <= r_mem[addrI];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HDR_HI;
            r_n        <= '0;
            r_byte_idx <= '0;
            r_shreg    <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
        end else begin
            case (r_state)
                HDR_HI: begin
                    if (w_accept) begin
                        r_n[15:8] <= s_data;
                        r_state   <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (w_accept) begin
                        r_n[7:0] <= s_data;
                        if (w_n_full == 16'd0) begin
                            r_state   <= DONE;
                            cpu_rst   <= 1'b0;
                            load_done <= 1'b1;
                        end else if (32'(w_n_full) > DEPTH) begin
                            r_state  <= ERROR;
                            load_err <= 1'b1;
                        end else begin
                            r_state    <= DATA;
                            r_byte_idx <= '0;
                            word_count <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_shreg <= w_word;
                        if (w_last_byte) begin
                            r_byte_idx <= '0;
                            word_count <= w_wc_next[RAM_SIZE:0];
                            if (w_wc_next == {1'b0, r_n}) begin
                                r_state   <= DONE;
                                cpu_rst   <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        r_state    <= HDR_HI;
                        r_byte_idx <= '0;
                        cpu_rst    <= 1'b1;
                        load_done  <= 1'b0;
                        word_count <= '0;
                    end
                end
                ERROR: begin
                    cpu_rst  <= 1'b1;
                    load_err <= 1'b1;
                end
                default: begin
                    r_state <= HDR_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: framed loads, backpressure,
// error header, empty frame, mid-load reset and read/write collision.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        reload = 1'b0;
    logic [9:0]  addrI = '0;
    logic [31:0] doutI;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [10:0] word_count;

    int checks = 0;
    int errors = 0;
    int readyCount = 0;

    imem_loader #(.MEMORY_WORD_SIZE(32), .RAM_SIZE(10)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .reload(reload), .addrI(addrI), .doutI(doutI), .cpu_rst(cpu_rst),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitCycles = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%h s_ready=%b required=1", b, s_ready);
        end else begin
            readyCount++;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic read_word(input logic [9:0] a, input logic [31:0] expWord, input string name);
        addrI = a;
        tick();
        checks++;
        if (doutI !== expWord) begin
            errors++;
            $display("FAIL %s doutI=%h required=%h", name, doutI, expWord);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({s_ready, cpu_rst, load_done, load_err} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags ready/cpu_rst/done/err=%b required=1100",
                     {s_ready, cpu_rst, load_done, load_err});
        end
        checks++;
        if (word_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_word_count got=%0d required=0", word_count);
        end
        checks++;
        if (doutI !== 32'h0) begin
            errors++;
            $display("FAIL reset_doutI got=%h required=00000000", doutI);
        end
        rst = 1'b0;
    endtask

    task automatic test_two_words();
        logic [7:0] frame [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                                   8'h9A, 8'hBC, 8'hDE, 8'hF0};
        readyCount = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                checks++;
                if (cpu_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL two_cpu_rst_before_last got=%b required=1", cpu_rst);
                end
            end
            send_byte(frame[i]);
        end
        checks++;
        if (readyCount !== 10) begin
            errors++;
            $display("FAIL two_ready_cycles got=%0d required=10", readyCount);
        end
        checks++;
        if ({load_done, cpu_rst, s_ready, load_err} !== 4'b1000) begin
            errors++;
            $display("FAIL two_done_flags done/cpu_rst/ready/err=%b required=1000",
                     {load_done, cpu_rst, s_ready, load_err});
        end
        checks++;
        if (word_count !== 11'd2) begin
            errors++;
            $display("FAIL two_word_count got=%0d required=2", word_count);
        end
    endtask

    task automatic test_read();
        read_word(10'd1, 32'h9ABCDEF0, "read_addr1");
        read_word(10'd0, 32'h12345678, "read_addr0");
    endtask

    task automatic test_gap();
        pulse_reload();
        checks++;
        if ({cpu_rst, load_done, s_ready} !== 3'b101 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL gap_after_reload cpu_rst/done/ready=%b wc=%0d required=101 wc=0",
                     {cpu_rst, load_done, s_ready}, word_count);
        end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cpu_rst !== 1'b1 || word_count !== 11'd0 || load_done !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold cycle=%0d cpu_rst=%b wc=%0d done=%b required=1 0 0",
                         i, cpu_rst, word_count, load_done);
            end
        end
        send_byte(8'hCC);
        send_byte(8'hDD);
        checks++;
        if (load_done !== 1'b1 || word_count !== 11'd1) begin
            errors++;
            $display("FAIL gap_done done=%b wc=%0d required=1 1", load_done, word_count);
        end
        read_word(10'd0, 32'hAABBCCDD, "gap_mem0");
    endtask

    task automatic test_error();
        pulse_reload();
        send_byte(8'h04);
        send_byte(8'h01);
        checks++;
        if ({load_err, s_ready, cpu_rst, load_done} !== 4'b1010) begin
            errors++;
            $display("FAIL err_flags err/ready/cpu_rst/done=%b required=1010",
                     {load_err, s_ready, cpu_rst, load_done});
        end
        pulse_reload();
        tick();
        checks++;
        if ({load_err, s_ready, cpu_rst, load_done} !== 4'b1010) begin
            errors++;
            $display("FAIL err_reload_ignored err/ready/cpu_rst/done=%b required=1010",
                     {load_err, s_ready, cpu_rst, load_done});
        end
        pulse_reset();
        checks++;
        if ({load_err, s_ready, cpu_rst, load_done} !== 4'b0110) begin
            errors++;
            $display("FAIL err_rst_exit err/ready/cpu_rst/done=%b required=0110",
                     {load_err, s_ready, cpu_rst, load_done});
        end
    endtask

    task automatic test_zero_then_reload();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({load_done, cpu_rst, s_ready} !== 3'b100 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL zero_done done/cpu_rst/ready=%b wc=%0d required=100 wc=0",
                     {load_done, cpu_rst, s_ready}, word_count);
        end
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        checks++;
        if (load_done !== 1'b1 || word_count !== 11'd1) begin
            errors++;
            $display("FAIL zero_reload_done done=%b wc=%0d required=1 1", load_done, word_count);
        end
        read_word(10'd0, 32'h01020304, "zero_reload_mem0");
    endtask

    task automatic test_midword_rst();
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_reset();
        addrI = 10'd0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        checks++;
        if (doutI !== 32'h01020304) begin
            errors++;
            $display("FAIL collision_old_data doutI=%h required=01020304", doutI);
        end
        tick();
        checks++;
        if (doutI !== 32'h55667788) begin
            errors++;
            $display("FAIL midword_mem0 doutI=%h required=55667788", doutI);
        end
        checks++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || word_count !== 11'd1) begin
            errors++;
            $display("FAIL midword_done done=%b cpu_rst=%b wc=%0d required=1 0 1",
                     load_done, cpu_rst, word_count);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_two_words();
        test_read();
        test_gap();
        test_error();
        test_zero_then_reload();
        test_midword_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory writer and read responder: owns the instruction RAM that the CPU control unit fetches from over addrI/doutI.
- Accepts a byte stream over a valid/ready handshake and packs it into MEMORY_WORD_SIZE-bit words, MSB byte first.
- Writes the words into the RAM from address 0 upward.
- Holds the CPU in reset via cpu_rst until the load completes.

Parameters:
- MEMORY_WORD_SIZE, 32, instruction word width; must be a multiple of 8.
- RAM_SIZE, 10, address width; depth DEPTH = 2^RAM_SIZE words.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  loader byte valid
- s_data  in  8  loader byte
- s_ready  out  1  loader byte ready; a byte is accepted on a clk edge where s_valid && s_ready
- reload  in  1  single-cycle pulse; restarts loading from DONE
- addrI  in  RAM_SIZE  CPU instruction fetch address
- doutI  out  MEMORY_WORD_SIZE  CPU instruction data, registered
- cpu_rst  out  1  high while no complete program is loaded
- load_done  out  1  high in DONE
- load_err  out  1  high in ERROR (sticky)
- word_count  out  RAM_SIZE+1  words written so far in the current load

Behaviour:
- Reset values: state=HDR_HI, cpu_rst=1, load_done=0, load_err=0, word_count=0, doutI=0, byte index=0, N=0.
- RAM contents are not cleared by rst.
- Read port:
  - Every clk edge, doutI <= mem[addrI]. Latency is 1 cycle and does not depend on state.
  - When a read and a write hit the same address on the same edge, doutI returns the old data.
- Frame format: 2-byte big-endian word count N, followed by N*(MEMORY_WORD_SIZE/8) data bytes.
- States and transitions:
  - HDR_HI: s_ready=1. On accept: N[15:8] <= s_data, go to HDR_LO.
  - HDR_LO: s_ready=1. On accept: N[7:0] <= s_data, then
    - if the full N == 0: go to DONE;
    - else if N > DEPTH: go to ERROR;
    - else go to DATA with byte index=0 and word_count=0.
  - DATA: s_ready=1.
    - Each accepted byte shifts into the assembly register: shreg <= {shreg[W-9:0], s_data}, where W = MEMORY_WORD_SIZE.
    - On the accept of the last byte of a word (byte index = W/8-1), on that same edge: mem[word_count] <= {shreg[W-9:0], s_data}, word_count += 1, byte index <= 0.
    - If word_count+1 == N on that edge, go to DONE.
  - DONE: s_ready=0, load_done=1, cpu_rst=0 from the cycle after entry.
    - On reload=1: go to HDR_HI with cpu_rst=1, load_done=0, word_count=0.
    - word_count holds N until then.
  - ERROR: s_ready=0, load_err=1, cpu_rst=1. Exited only by rst; reload is ignored.
- All outputs are registered except s_ready, which is decoded from state.
- cpu_rst stays high through HDR_HI, HDR_LO, DATA and ERROR. There are no glitches on cpu_rst.
- reload outside DONE is ignored.
- Backpressure: s_valid may drop mid-word; the partial word is held indefinitely.
- rst mid-load: returns to HDR_HI and discards any partial word. Already-written RAM words remain, but cpu_rst=1 until a new complete load.
- N == DEPTH is legal and fills every address. The address never wraps.

Test Plan:
- Reset, then stream 00 02 | 12 34 56 78 | 9A BC DE F0 with s_valid held high -> s_ready high for 10 cycles. mem[0]=0x12345678 and mem[1]=0x9ABCDEF0. word_count=2. load_done=1. cpu_rst falls 1 cycle after the last accept.
- After the load, drive addrI=1 then addrI=0 on consecutive cycles -> doutI=0x9ABCDEF0 and then 0x12345678, each one cycle after its address.
- Stream 00 01 | AA BB with a 5-cycle s_valid gap, then CC DD -> mem[0]=0xAABBCCDD. cpu_rst stays 1 throughout the gap.
- Header 04 01 (N=1025 > 1024) -> load_err=1, s_ready=0, cpu_rst=1. A reload pulse changes nothing; rst restores HDR_HI.
- Header 00 00 -> DONE immediately, word_count=0, cpu_rst=0. Then reload, stream 00 01 | 01 02 03 04 -> mem[0]=0x01020304, word_count=1.
- Mid-word rst after 00 01 | 11 22, then a full load of 00 01 | 55 66 77 88 -> mem[0]=0x55667788 and no residue of 0x1122.
